// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Imported by pipe_fwd_unit and pipe_hazard_ctrl.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_hit(
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic       en
  );
    return en && (src == dst) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Register-address comparators feeding both the stall decision
// and the ALU operand forward selects.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] exs_rs1,
  input  logic [4:0] exs_rs2,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd_addr,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_reg_write,
  output logic       load_use,
  output logic       raw_hz,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic ex_hit1, ex_hit2;
  logic mem_hit1, mem_hit2;

  assign ex_hit1  = reg_hit(id_rs1_addr, ex_rd_addr, id_use_rs1);
  assign ex_hit2  = reg_hit(id_rs2_addr, ex_rd_addr, id_use_rs2);
  assign mem_hit1 = reg_hit(id_rs1_addr, mem_rd_addr, id_use_rs1);
  assign mem_hit2 = reg_hit(id_rs2_addr, mem_rd_addr, id_use_rs2);

  assign load_use = ex_mem_read && (ex_hit1 || ex_hit2);

  assign raw_hz = (ex_reg_write && (ex_hit1 || ex_hit2))
               || (mem_reg_write && (mem_hit1 || mem_hit2));

  // Youngest producer wins: EX/MEM before MEM/WB.
  always_comb begin
    fwd_a = FWD_IDEX;
    if (reg_hit(exs_rs1, mem_rd_addr, mem_reg_write))
      fwd_a = FWD_EXMEM;
    else if (reg_hit(exs_rs1, wb_rd_addr, wb_reg_write))
      fwd_a = FWD_MEMWB;
  end

  // Same selection for operand B.
  always_comb begin
    fwd_b = FWD_IDEX;
    if (reg_hit(exs_rs2, mem_rd_addr, mem_reg_write))
      fwd_b = FWD_EXMEM;
    else if (reg_hit(exs_rs2, wb_rd_addr, wb_reg_write))
      fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / stall / flush controller for the 5-stage core.
// Define FORWARD_EN to enable EX-stage operand forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_reg_write,
  input  logic             ex_br_taken,
  input  logic             dm_req,
  input  logic             dm_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             dm_abort,
  output logic             mem_err,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  logic       load_use, raw_hz, stall;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] exs_rs1, exs_rs2;
  logic       timeout, freeze, abort;
  logic       br_apply;

  pipe_fwd_unit u_fwd (
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .exs_rs1       (exs_rs1),
    .exs_rs2       (exs_rs2),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .load_use      (load_use),
    .raw_hz        (raw_hz),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

`ifdef FORWARD_EN
  logic unused_raw;
  assign unused_raw = raw_hz;
  assign stall      = load_use;

  // Track ID/EX sources; a bubble carries no operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exs_rs1 <= REG_ZERO;
      exs_rs2 <= REG_ZERO;
    end else if (id_ex_write) begin
      if (id_ex_bubble) begin
        exs_rs1 <= REG_ZERO;
        exs_rs2 <= REG_ZERO;
      end else begin
        exs_rs1 <= id_use_rs1 ? id_rs1_addr : REG_ZERO;
        exs_rs2 <= id_use_rs2 ? id_rs2_addr : REG_ZERO;
      end
    end
  end
`else
  logic [3:0] unused_fwd;
  assign unused_fwd = {fwd_a, fwd_b};
  assign stall      = load_use || raw_hz;
  assign exs_rs1    = REG_ZERO;
  assign exs_rs2    = REG_ZERO;
`endif

  assign timeout = (wait_cnt == WC_W'(MEM_TIMEOUT));

  assign freeze = (state == RUN && dm_req && !dm_ready)
               || (state == MEM_WAIT && !dm_ready && !timeout);

  assign abort = (state == MEM_WAIT) && !dm_ready && timeout;

  assign br_apply = !freeze && ex_br_taken;

  // Pipeline enables, bubbles and forward selects.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    dm_abort      = 1'b0;
    fwd_a_sel     = FWD_IDEX;
    fwd_b_sel     = FWD_IDEX;
    if (!rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_write   = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else begin
`ifdef FORWARD_EN
      fwd_a_sel = fwd_a;
      fwd_b_sel = fwd_b;
`endif
      if (abort) begin
        dm_abort      = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      if (ex_br_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Memory-wait FSM, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (dm_req && !dm_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dm_ready || abort) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
          if (abort)
            mem_err <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating stall / flush statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_apply && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Expectations switch on FORWARD_EN where behaviour differs.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, mwb_bub, abort}
  localparam logic [7:0] CTL_RST = 8'b0010_1010;
  localparam logic [7:0] CTL_RUN = 8'b1101_0100;
  localparam logic [7:0] CTL_STL = 8'b0001_1100;
  localparam logic [7:0] CTL_BR  = 8'b1111_1100;
  localparam logic [7:0] CTL_FRZ = 8'b0000_0010;

  logic clk;
  logic rst;
  logic [4:0] id_rs1_addr, id_rs2_addr;
  logic id_use_rs1, id_use_rs2;
  logic [4:0] ex_rd_addr;
  logic ex_reg_write, ex_mem_read;
  logic [4:0] mem_rd_addr;
  logic mem_reg_write;
  logic [4:0] wb_rd_addr;
  logic wb_reg_write;
  logic ex_br_taken, dm_req, dm_ready;
  logic pc_write, if_id_write, if_id_flush;
  logic id_ex_write, id_ex_bubble, ex_mem_write;
  logic mem_wb_bubble, dm_abort, mem_err;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write, if_id_write, if_id_flush,
                id_ex_write, id_ex_bubble, ex_mem_write,
                mem_wb_bubble, dm_abort};

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .ex_br_taken   (ex_br_taken),
    .dm_req        (dm_req),
    .dm_ready      (dm_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_bubble (mem_wb_bubble),
    .dm_abort      (dm_abort),
    .mem_err       (mem_err),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle();
    id_rs1_addr   = 5'd0;
    id_rs2_addr   = 5'd0;
    id_use_rs1    = 1'b0;
    id_use_rs2    = 1'b0;
    ex_rd_addr    = 5'd0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    mem_rd_addr   = 5'd0;
    mem_reg_write = 1'b0;
    wb_rd_addr    = 5'd0;
    wb_reg_write  = 1'b0;
    ex_br_taken   = 1'b0;
    dm_req        = 1'b0;
    dm_ready      = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2);
    id_rs1_addr = r1;
    id_rs2_addr = r2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic rw,
                        input logic mr);
    ex_rd_addr   = rd;
    ex_reg_write = rw;
    ex_mem_read  = mr;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    next();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RST) begin
      errors++;
      $display("FAIL rst_ctl: got %b want %b", ctl, CTL_RST);
    end
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_fwd: got %b want 0000",
               {fwd_a_sel, fwd_b_sel});
    end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_regs: got %0d/%0d/%b want 0/0/0",
               stall_cnt, flush_cnt, mem_err);
    end
    next();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== CTL_RUN || {fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ctl[%0d]: got %b/%b want %b/0000",
                 i, ctl, {fwd_a_sel, fwd_b_sel}, CTL_RUN);
      end
      next();
    end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL idle_cnt: got %0d/%0d want 0/0",
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd5, 5'd1, 1'b1, 1'b1);
    set_ex(5'd5, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== CTL_STL) begin
      errors++;
      $display("FAIL lu_stall: got %b want %b", ctl, CTL_STL);
    end
    next();
    set_ex(5'd0, 1'b0, 1'b0);
    mem_rd_addr   = 5'd5;
    mem_reg_write = 1'b1;
    @(negedge clk);
    checks++;
`ifdef FORWARD_EN
    if (ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL lu_after: got %b want %b", ctl, CTL_RUN);
    end
    next();
    set_id(5'd0, 5'd0, 1'b0, 1'b0);
    set_ex(5'd6, 1'b1, 1'b0);
    mem_rd_addr   = 5'd0;
    mem_reg_write = 1'b0;
    wb_rd_addr    = 5'd5;
    wb_reg_write  = 1'b1;
    @(negedge clk);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0100 || ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL lu_fwd: got %b/%b want 0100/%b",
               {fwd_a_sel, fwd_b_sel}, ctl, CTL_RUN);
    end
    next();
    idle();
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
    end
`else
    if (ctl !== CTL_STL) begin
      errors++;
      $display("FAIL lu_stall2: got %b want %b", ctl, CTL_STL);
    end
    next();
    mem_rd_addr   = 5'd0;
    mem_reg_write = 1'b0;
    wb_rd_addr    = 5'd5;
    wb_reg_write  = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RUN || {fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++;
      $display("FAIL lu_release: got %b/%b want %b/0000",
               ctl, {fwd_a_sel, fwd_b_sel}, CTL_RUN);
    end
    next();
    idle();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL lu_cnt: got %0d want 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_raw();
    do_reset();
    set_id(5'd7, 5'd0, 1'b1, 1'b0);
    set_ex(5'd7, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
`ifdef FORWARD_EN
    if (ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL raw_nostall: got %b want %b", ctl, CTL_RUN);
    end
    next();
    set_id(5'd0, 5'd0, 1'b0, 1'b0);
    set_ex(5'd8, 1'b1, 1'b0);
    mem_rd_addr   = 5'd7;
    mem_reg_write = 1'b1;
    wb_rd_addr    = 5'd7;
    wb_reg_write  = 1'b1;
    @(negedge clk);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
      errors++;
      $display("FAIL raw_fwd: got %b want 1000",
               {fwd_a_sel, fwd_b_sel});
    end
    next();
    idle();
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL raw_cnt: got %0d want 0", stall_cnt);
    end
`else
    if (ctl !== CTL_STL) begin
      errors++;
      $display("FAIL raw_stall1: got %b want %b", ctl, CTL_STL);
    end
    next();
    set_ex(5'd0, 1'b0, 1'b0);
    mem_rd_addr   = 5'd7;
    mem_reg_write = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_STL) begin
      errors++;
      $display("FAIL raw_stall2: got %b want %b", ctl, CTL_STL);
    end
    next();
    mem_rd_addr   = 5'd0;
    mem_reg_write = 1'b0;
    wb_rd_addr    = 5'd7;
    wb_reg_write  = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL raw_wb: got %b want %b", ctl, CTL_RUN);
    end
    next();
    idle();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL raw_cnt: got %0d want 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_branch_load_use();
    do_reset();
    set_id(5'd5, 5'd1, 1'b1, 1'b1);
    set_ex(5'd5, 1'b1, 1'b1);
    ex_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_BR) begin
      errors++;
      $display("FAIL br_lu: got %b want %b", ctl, CTL_BR);
    end
    next();
    idle();
    checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL br_cnt: got %0d/%0d want 1/0",
               flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    dm_req      = 1'b1;
    ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== CTL_FRZ) begin
        errors++;
        $display("FAIL mw_freeze[%0d]: got %b want %b",
                 i, ctl, CTL_FRZ);
      end
      next();
    end
    dm_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_BR) begin
      errors++;
      $display("FAIL mw_release: got %b want %b", ctl, CTL_BR);
    end
    next();
    idle();
    checks++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL mw_cnt: got %0d/%0d want 3/1",
               stall_cnt, flush_cnt);
    end
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL mw_run: got %b want %b", ctl, CTL_RUN);
    end
    next();
  endtask

  task automatic test_timeout();
    do_reset();
    dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== CTL_FRZ || mem_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d]: got %b/%b want %b/0",
                 i, ctl, mem_err, CTL_FRZ);
      end
      next();
    end
    @(negedge clk);
    checks++;
    if (ctl[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL to_abort: got %b want 11", ctl[1:0]);
    end
    next();
    dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RUN || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL to_after: got %b/%b want %b/1",
               ctl, mem_err, CTL_RUN);
    end
    for (int i = 0; i < 3; i++) next();
    checks++;
    if (mem_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got %b want 1", mem_err);
    end
    dm_req = 1'b1;
    @(negedge clk);
    next();
    @(negedge clk);
    checks++;
    if (ctl !== CTL_FRZ) begin
      errors++;
      $display("FAIL to_rewait: got %b want %b", ctl, CTL_FRZ);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RST || mem_err !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL to_rst: got %b/%b/%0d want %b/0/0",
               ctl, mem_err, stall_cnt, CTL_RST);
    end
    next();
    rst    = 1'b1;
    dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++;
      $display("FAIL to_rst_run: got %b want %b", ctl, CTL_RUN);
    end
    next();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_raw();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
